// File: rtl/raytracer_pkg.sv
// Shared raytracer definitions: Q8.8 format, accumulator width, saturation
// limits and the ray generator state encoding.
package raytracer_pkg;

   localparam int Q_W   = 16;
   localparam int ACC_W = 24;

   localparam logic signed [Q_W-1:0] Q_MAX = 16'sh7FFF;
   localparam logic signed [Q_W-1:0] Q_MIN = 16'sh8000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } rg_state_e;

   // Sign-extend a Q8.8 value into the wide accumulator format.
   function automatic logic signed [ACC_W-1:0] q_to_acc(input logic signed [Q_W-1:0] v);
      return {{(ACC_W-Q_W){v[Q_W-1]}}, v};
   endfunction

endpackage

// File: rtl/q88_sat.sv
// Saturating conversion from the wide signed accumulator to Q8.8.
module q88_sat
   import raytracer_pkg::*;
(
   input  logic signed [ACC_W-1:0] acc_i,
   output logic signed [Q_W-1:0]   q_o
);

   logic [ACC_W-Q_W:0] top_s;

   // In range only when every bit above the Q8.8 sign bit matches it.
   assign top_s = acc_i[ACC_W-1:Q_W-1];

   // Clamp out-of-range values toward the sign of the accumulator.
   always_comb begin
      if ((&top_s) || (~|top_s)) begin
         q_o = acc_i[Q_W-1:0];
      end else if (acc_i[ACC_W-1]) begin
         q_o = Q_MIN;
      end else begin
         q_o = Q_MAX;
      end
   end

endmodule

// File: rtl/ray_gen.sv
// Camera ray generator: scans an H_RES x V_RES frame and emits one primary
// ray per pixel through a valid/ready handshake.
module ray_gen
   import raytracer_pkg::*;
#(
   parameter int H_RES = 64,
   parameter int V_RES = 48
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         start,
   input  logic                         abort,
   input  logic signed [Q_W-1:0]        cam_origin_x,
   input  logic signed [Q_W-1:0]        cam_origin_y,
   input  logic signed [Q_W-1:0]        cam_origin_z,
   input  logic signed [Q_W-1:0]        focal,
   input  logic signed [Q_W-1:0]        step,
   input  logic                         out_ready,
   output logic                         valid_out,
   output logic signed [Q_W-1:0]        ray_origin_x,
   output logic signed [Q_W-1:0]        ray_origin_y,
   output logic signed [Q_W-1:0]        ray_origin_z,
   output logic signed [Q_W-1:0]        ray_dir_x,
   output logic signed [Q_W-1:0]        ray_dir_y,
   output logic signed [Q_W-1:0]        ray_dir_z,
   output logic [$clog2(H_RES)-1:0]     pix_x,
   output logic [$clog2(V_RES)-1:0]     pix_y,
   output logic                         last,
   output logic                         busy,
   output logic                         done
);

   localparam int PX_W = $clog2(H_RES);
   localparam int PY_W = $clog2(V_RES);
   localparam logic [PX_W-1:0] X_LAST = PX_W'(H_RES - 1);
   localparam logic [PY_W-1:0] Y_LAST = PY_W'(V_RES - 1);
   localparam logic signed [ACC_W-1:0] HALF_H = ACC_W'(H_RES / 2);
   localparam logic signed [ACC_W-1:0] HALF_V = ACC_W'(V_RES / 2);

   rg_state_e               state_q, state_d;
   logic                    valid_q, valid_d;
   logic                    last_q, last_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic [PX_W-1:0]         pix_x_q, pix_x_d;
   logic [PY_W-1:0]         pix_y_q, pix_y_d;
   logic signed [ACC_W-1:0] acc_x_q, acc_x_d;
   logic signed [ACC_W-1:0] acc_y_q, acc_y_d;
   logic signed [ACC_W-1:0] row_x_q, row_x_d;
   logic signed [Q_W-1:0]   step_q, step_d;
   logic signed [Q_W-1:0]   focal_q, focal_d;
   logic signed [Q_W-1:0]   org_x_q, org_x_d;
   logic signed [Q_W-1:0]   org_y_q, org_y_d;
   logic signed [Q_W-1:0]   org_z_q, org_z_d;
   logic signed [Q_W-1:0]   dir_x_q, dir_y_q;
   logic signed [Q_W-1:0]   dir_x_s, dir_y_s;
   logic signed [ACC_W-1:0] x_start_s, y_start_s;

   // First-pixel directions; row_x_q keeps the x start so line wraps need no multiply.
   assign x_start_s = -(HALF_H * q_to_acc(step));
   assign y_start_s = HALF_V * q_to_acc(step);

   // Next-state logic for the scan FSM and the direction accumulators.
   always_comb begin
      state_d = state_q;
      valid_d = valid_q;
      last_d  = last_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      pix_x_d = pix_x_q;
      pix_y_d = pix_y_q;
      acc_x_d = acc_x_q;
      acc_y_d = acc_y_q;
      row_x_d = row_x_q;
      step_d  = step_q;
      focal_d = focal_q;
      org_x_d = org_x_q;
      org_y_d = org_y_q;
      org_z_d = org_z_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               step_d  = step;
               focal_d = focal;
               org_x_d = cam_origin_x;
               org_y_d = cam_origin_y;
               org_z_d = cam_origin_z;
               acc_x_d = x_start_s;
               row_x_d = x_start_s;
               acc_y_d = y_start_s;
               pix_x_d = '0;
               pix_y_d = '0;
               valid_d = 1'b1;
               busy_d  = 1'b1;
               last_d  = 1'b0;
               state_d = ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            // Abort takes priority over any transfer in the same cycle.
            if (abort) begin
               valid_d = 1'b0;
               busy_d  = 1'b0;
               last_d  = 1'b0;
               state_d = ST_IDLE;
            end else if (valid_q && out_ready) begin
               if (last_q) begin
                  valid_d = 1'b0;
                  busy_d  = 1'b0;
                  last_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = ST_DONE;
               end else if (pix_x_q == X_LAST) begin
                  pix_x_d = '0;
                  pix_y_d = pix_y_q + PY_W'(1);
                  acc_x_d = row_x_q;
                  acc_y_d = acc_y_q - q_to_acc(step_q);
                  last_d  = 1'b0;
               end else begin
                  pix_x_d = pix_x_q + PX_W'(1);
                  acc_x_d = acc_x_q + q_to_acc(step_q);
                  last_d  = ((pix_x_q + PX_W'(1)) == X_LAST) && (pix_y_q == Y_LAST);
               end
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            valid_d = 1'b0;
            busy_d  = 1'b0;
            last_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   q88_sat u_sat_x (
      .acc_i (acc_x_d),
      .q_o   (dir_x_s)
   );

   q88_sat u_sat_y (
      .acc_i (acc_y_d),
      .q_o   (dir_y_s)
   );

   // State, datapath and output registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pix_x_q <= '0;
         pix_y_q <= '0;
         acc_x_q <= '0;
         acc_y_q <= '0;
         row_x_q <= '0;
         step_q  <= '0;
         focal_q <= '0;
         org_x_q <= '0;
         org_y_q <= '0;
         org_z_q <= '0;
         dir_x_q <= '0;
         dir_y_q <= '0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pix_x_q <= pix_x_d;
         pix_y_q <= pix_y_d;
         acc_x_q <= acc_x_d;
         acc_y_q <= acc_y_d;
         row_x_q <= row_x_d;
         step_q  <= step_d;
         focal_q <= focal_d;
         org_x_q <= org_x_d;
         org_y_q <= org_y_d;
         org_z_q <= org_z_d;
         dir_x_q <= dir_x_s;
         dir_y_q <= dir_y_s;
      end
   end

   assign valid_out    = valid_q;
   assign last         = last_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign pix_x        = pix_x_q;
   assign pix_y        = pix_y_q;
   assign ray_origin_x = org_x_q;
   assign ray_origin_y = org_y_q;
   assign ray_origin_z = org_z_q;
   assign ray_dir_x    = dir_x_q;
   assign ray_dir_y    = dir_y_q;
   assign ray_dir_z    = focal_q;

endmodule

// File: tb/tb_ray_gen.sv
// Self-checking bench for ray_gen (4x2 frame): directed scenarios plus a
// randomized run, all checked every cycle against a frame-level model.
module tb_ray_gen;

   localparam int H    = 4;
   localparam int V    = 2;
   localparam int NPIX = H * V;
   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_DONE = 2;

   logic        clock = 1'b0;
   logic        reset, start, abort, out_ready;
   logic [15:0] cam_origin_x, cam_origin_y, cam_origin_z, focal, step;
   logic        valid_out, last, busy, done;
   logic [15:0] ray_origin_x, ray_origin_y, ray_origin_z;
   logic [15:0] ray_dir_x, ray_dir_y, ray_dir_z;
   logic [1:0]  pix_x;
   logic [0:0]  pix_y;

   int n_checks = 0;
   int n_fail   = 0;

   // Model: frame phase, index of the pixel currently presented, latched inputs.
   int          m_state = M_IDLE;
   int          m_idx   = 0;
   logic [15:0] m_ox, m_oy, m_oz, m_focal, m_step;

   always #5 clock = ~clock;

   ray_gen #(.H_RES(H), .V_RES(V)) dut (
      .clock(clock), .reset(reset), .start(start), .abort(abort),
      .cam_origin_x(cam_origin_x), .cam_origin_y(cam_origin_y), .cam_origin_z(cam_origin_z),
      .focal(focal), .step(step), .out_ready(out_ready), .valid_out(valid_out),
      .ray_origin_x(ray_origin_x), .ray_origin_y(ray_origin_y), .ray_origin_z(ray_origin_z),
      .ray_dir_x(ray_dir_x), .ray_dir_y(ray_dir_y), .ray_dir_z(ray_dir_z),
      .pix_x(pix_x), .pix_y(pix_y), .last(last), .busy(busy), .done(done)
   );

   function automatic logic [15:0] sat16(input int v);
      int t;
      logic [15:0] r;
      if (v > 32767) r = 16'h7FFF;
      else if (v < -32768) r = 16'h8000;
      else begin
         t = v;
         r = t[15:0];
      end
      return r;
   endfunction

   function automatic logic [15:0] exp_dx(input int idx, input logic [15:0] st);
      int s;
      s = $signed(st);
      return sat16(((idx % H) - H / 2) * s);
   endfunction

   function automatic logic [15:0] exp_dy(input int idx, input logic [15:0] st);
      int s;
      s = $signed(st);
      return sat16((V / 2 - idx / H) * s);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      chk("valid", 32'(valid_out), 32'(m_state == M_RUN));
      chk("busy",  32'(busy),      32'(m_state == M_RUN));
      chk("done",  32'(done),      32'(m_state == M_DONE));
      if (m_state == M_RUN) begin
         chk("pix_x", 32'(pix_x), 32'(m_idx % H));
         chk("pix_y", 32'(pix_y), 32'(m_idx / H));
         chk("last",  32'(last),  32'(m_idx == NPIX - 1));
         chk("org_x", 32'(ray_origin_x), 32'(m_ox));
         chk("org_y", 32'(ray_origin_y), 32'(m_oy));
         chk("org_z", 32'(ray_origin_z), 32'(m_oz));
         chk("dir_x", 32'(ray_dir_x), 32'(exp_dx(m_idx, m_step)));
         chk("dir_y", 32'(ray_dir_y), 32'(exp_dy(m_idx, m_step)));
         chk("dir_z", 32'(ray_dir_z), 32'(m_focal));
      end else begin
         chk("last_idle", 32'(last), 32'd0);
      end
   endtask

   task automatic chk_reset_vals();
      chk("rst_valid", 32'(valid_out), 32'd0);
      chk("rst_last",  32'(last),  32'd0);
      chk("rst_busy",  32'(busy),  32'd0);
      chk("rst_done",  32'(done),  32'd0);
      chk("rst_pix_x", 32'(pix_x), 32'd0);
      chk("rst_pix_y", 32'(pix_y), 32'd0);
      chk("rst_org_x", 32'(ray_origin_x), 32'd0);
      chk("rst_org_y", 32'(ray_origin_y), 32'd0);
      chk("rst_org_z", 32'(ray_origin_z), 32'd0);
      chk("rst_dir_x", 32'(ray_dir_x), 32'd0);
      chk("rst_dir_y", 32'(ray_dir_y), 32'd0);
      chk("rst_dir_z", 32'(ray_dir_z), 32'd0);
   endtask

   // Advance the model on the inputs seen at this edge, clock, then compare.
   task automatic tick();
      if (reset) begin
         m_state = M_IDLE;
      end else begin
         case (m_state)
            M_IDLE: if (start) begin
               m_ox = cam_origin_x; m_oy = cam_origin_y; m_oz = cam_origin_z;
               m_focal = focal; m_step = step;
               m_idx = 0;
               m_state = M_RUN;
            end
            M_RUN: begin
               if (abort) m_state = M_IDLE;
               else if (out_ready) begin
                  m_idx++;
                  if (m_idx == NPIX) m_state = M_DONE;
               end
            end
            default: m_state = M_IDLE;
         endcase
      end
      @(posedge clock);
      #1;
      check_outputs();
   endtask

   task automatic run_until_idle(input int mode, input int budget);
      for (int c = 0; c < budget; c++) begin
         if (m_state == M_IDLE) break;
         case (mode)
            0: out_ready = 1'b1;
            1: out_ready = (c % 2 == 0);
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         tick();
      end
      chk("frame_end_busy", 32'(busy), 32'd0);
   endtask

   task automatic begin_frame(input logic [15:0] st, input logic [15:0] fo);
      step = st; focal = fo; start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
      cam_origin_x = 16'h0123; cam_origin_y = 16'hFF00; cam_origin_z = 16'h0A80;
      focal = 16'h0000; step = 16'h0000;
      #1;
      tick();
      tick();
      chk_reset_vals();
      reset = 1'b0;
      tick();

      // Basic frame, always ready: first and last ray against hand values.
      out_ready = 1'b1;
      begin_frame(16'h0100, 16'h0200);
      chk("r037_first_dx", 32'(ray_dir_x), 32'h0000FE00);
      chk("r037_first_dy", 32'(ray_dir_y), 32'h00000100);
      chk("r037_first_dz", 32'(ray_dir_z), 32'h00000200);
      for (int i = 0; i < 7; i++) tick();
      chk("r037_last_dx", 32'(ray_dir_x), 32'h00000100);
      chk("r037_last_dy", 32'(ray_dir_y), 32'h00000000);
      chk("r037_last_flag", 32'(last), 32'd1);
      tick();
      chk("r037_done", 32'(done), 32'd1);
      chk("r037_valid_low", 32'(valid_out), 32'd0);
      tick();
      chk("r037_done_once", 32'(done), 32'd0);

      // Stalls with out_ready toggling.
      out_ready = 1'b0;
      begin_frame(16'h0100, 16'h0200);
      run_until_idle(1, 60);

      // Saturation of the x direction.
      out_ready = 1'b0;
      begin_frame(16'h7000, 16'h0300);
      chk("r039_sat_dx", 32'(ray_dir_x), 32'h00008000);
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      chk("r039_px3_dx", 32'(ray_dir_x), 32'h00007000);
      run_until_idle(0, 20);

      // Abort after the third transfer, then restart.
      out_ready = 1'b1;
      begin_frame(16'h0100, 16'h0200);
      for (int i = 0; i < 3; i++) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("r040_valid", 32'(valid_out), 32'd0);
      chk("r040_busy", 32'(busy), 32'd0);
      for (int i = 0; i < 3; i++) tick();
      begin_frame(16'h0080, 16'h0100);
      chk("r040_restart_x", 32'(pix_x), 32'd0);
      chk("r040_restart_y", 32'(pix_y), 32'd0);
      run_until_idle(0, 20);

      // Start re-pulsed mid-frame with a new origin is ignored.
      cam_origin_x = 16'h1111; cam_origin_y = 16'h2222; cam_origin_z = 16'h3333;
      out_ready = 1'b0;
      begin_frame(16'hFF40, 16'h0400);
      out_ready = 1'b1;
      tick();
      cam_origin_x = 16'h5A5A; cam_origin_y = 16'hA5A5; cam_origin_z = 16'h7E7E;
      step = 16'h0001; focal = 16'h0001; start = 1'b1;
      tick();
      tick();
      start = 1'b0;
      chk("r041_org_x", 32'(ray_origin_x), 32'h00001111);
      run_until_idle(1, 40);

      // Start held across DONE is taken in the following IDLE cycle.
      out_ready = 1'b1; step = 16'h0100; focal = 16'h0200; start = 1'b1;
      for (int i = 0; i < 11; i++) tick();
      start = 1'b0;
      chk("r032_restart_valid", 32'(valid_out), 32'd1);
      chk("r032_restart_x", 32'(pix_x), 32'd0);
      run_until_idle(0, 20);

      // Start and abort together in IDLE starts the frame; abort in DONE is harmless.
      start = 1'b1; abort = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      chk("r031_start_wins", 32'(valid_out), 32'd1);
      for (int i = 0; i < 8; i++) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      tick();

      // Randomized traffic: inputs change every cycle, model tracks everything.
      for (int c = 0; c < 600; c++) begin
         start        = ($urandom_range(0, 3) == 0);
         abort        = ($urandom_range(0, 24) == 0);
         out_ready    = 1'($urandom_range(0, 1));
         cam_origin_x = 16'($urandom);
         cam_origin_y = 16'($urandom);
         cam_origin_z = 16'($urandom);
         focal        = 16'($urandom);
         step         = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(0, 511));
         tick();
      end
      start = 1'b0; abort = 1'b0;
      run_until_idle(0, 20);

      // Reset mid-frame while stalled.
      out_ready = 1'b0;
      begin_frame(16'h0100, 16'h0200);
      tick();
      reset = 1'b1;
      tick();
      chk_reset_vals();
      reset = 1'b0;
      tick();
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ray_gen.md
RAY_GEN -- requirements
Module: ray_gen

Interface
REQ-001 Parameter H_RES, default 64, pixels per scanline (even, >=2).
REQ-002 Parameter V_RES, default 48, scanlines per frame (even, >=2).
REQ-003 Port clock  input  1  single clock, rising edge.
REQ-004 Port reset  input  1  synchronous, active-high.
REQ-005 Port start  input  1  begins a frame when sampled high in IDLE.
REQ-006 Port abort  input  1  terminates a frame in progress.
REQ-007 Port cam_origin_x/y/z  input  16 each  signed Q8.8 camera position, latched on accepted start.
REQ-008 Port focal  input  16  signed Q8.8 ray z-direction, latched on accepted start.
REQ-009 Port step  input  16  signed Q8.8 per-pixel direction increment, latched on accepted start.
REQ-010 Port out_ready  input  1  downstream intersect unit accepts a ray.
REQ-011 Port valid_out  output  1  ray fields valid.
REQ-012 Port ray_origin_x/y/z  output  16 each  signed Q8.8 ray origin.
REQ-013 Port ray_dir_x/y/z  output  16 each  signed Q8.8 ray direction, not normalized.
REQ-014 Port pix_x / pix_y  output  $clog2(H_RES) / $clog2(V_RES)  pixel tag of the current ray.
REQ-015 Port last  output  1  high with valid_out on the final pixel of the frame.
REQ-016 Port busy  output  1  high in RUN.
REQ-017 Port done  output  1  one-cycle pulse on normal frame completion.

Function
REQ-018 FSM states IDLE, RUN, DONE; reset enters IDLE.
REQ-019 IDLE, start=1: latch inputs; RUN next cycle with pixel (0,0) on outputs and valid_out=1.
REQ-020 start while in RUN or DONE is ignored.
REQ-021 Transfer occurs when valid_out and out_ready are both high in a cycle; otherwise all output fields hold stable.
REQ-022 valid_out never deasserts in RUN without a transfer, except on abort.
REQ-023 Scan order: pix_x increments per transfer; wraps at H_RES-1 to 0 and increments pix_y.
REQ-024 ray_dir_x = (pix_x - H_RES/2)*step; ray_dir_y = (V_RES/2 - pix_y)*step; ray_dir_z = focal.
REQ-025 Directions are computed incrementally in >=24-bit signed accumulators: add step per pixel, reload x at line wrap, subtract step per line.
REQ-026 ray_dir_x/ray_dir_y saturate to 16'sh7FFF / 16'sh8000 when the accumulator exceeds the Q8.8 range; accumulators themselves never saturate.
REQ-027 ray_origin_* equals the latched cam_origin_* for every ray of the frame.
REQ-028 last=1 exactly when pix_x=H_RES-1 and pix_y=V_RES-1 with valid_out=1.
REQ-029 Transfer of the last pixel: valid_out=0 next cycle; DONE for one cycle with done=1; IDLE afterward.
REQ-030 abort in RUN: valid_out=0 next cycle, IDLE next cycle, done stays 0; abort wins over a simultaneous transfer.
REQ-031 abort in IDLE or DONE has no effect; start and abort sampled together in IDLE: abort ignored, frame starts.
REQ-032 A start sampled in the IDLE cycle after DONE starts a new frame with no extra bubble.

Reset
REQ-033 Reset values: valid_out=0, last=0, busy=0, done=0, pix_x=0, pix_y=0; all ray fields 0.
REQ-034 Reset mid-frame discards the frame with no done pulse, regardless of out_ready.

Structure
REQ-035 Q8.8 width constant, saturation limits and the FSM state enum are in the shared raytracer package, shared with ray_sphere_intersect.
REQ-036 The saturating 24-to-16 Q8.8 conversion is a sub-module q88_sat, instantiated for x and y.

Verification
REQ-037 H_RES=4, V_RES=2, step=16'h0100, focal=16'h0200, out_ready=1, start -> 8 consecutive rays; first dir=(16'hFE00,16'h0100,16'h0200); last dir=(16'h0100,16'h0000,16'h0200) with last=1; done pulse 1 cycle later.
REQ-038 Same setup, out_ready toggling 1/0 -> all output fields stable during stalls; 8 transfers in scan order; no duplicate or skipped pixel.
REQ-039 step=16'h7000, H_RES=4 -> pixel (0,0) ray_dir_x=16'h8000 (saturated); pixel (3,0) ray_dir_x=16'h7000.
REQ-040 abort asserted after the 3rd transfer -> valid_out=0 next cycle, busy=0, done never pulses; new start restarts at (0,0).
REQ-041 start re-pulsed mid-frame and with cam_origin changed -> ignored; origin remains the latched value until done.
REQ-042 reset asserted mid-frame with out_ready=0 -> all outputs at reset values the next cycle.
